// File: rtl/hps_pkg.sv
// Shared types and elaboration helpers for the harmonic-product-spectrum engine.
package hps_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_OUT  = 2'd2,
    ST_DONE = 2'd3
  } hps_state_e;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

  // Full-precision width of a product before it is clamped back to the output width.
  function automatic int sat_mul_width(input int prod_width, input int mag_width);
    return prod_width + mag_width;
  endfunction

endpackage

// File: rtl/hps_sat_mul.sv
// Combinational saturating multiply: running product times one magnitude word,
// clamped to all-ones when the exact result does not fit the product width.
module hps_sat_mul
  import hps_pkg::*;
#(
  parameter int PROD_WIDTH = 32,
  parameter int MAG_WIDTH  = 16
) (
  input  logic [PROD_WIDTH-1:0] a,
  input  logic [MAG_WIDTH-1:0]  b,
  output logic [PROD_WIDTH-1:0] p,
  output logic                  sat
);

  localparam int FULL_W = sat_mul_width(PROD_WIDTH, MAG_WIDTH);

  logic [FULL_W-1:0] full;

  always_comb begin
    full = {{MAG_WIDTH{1'b0}}, a} * {{PROD_WIDTH{1'b0}}, b};
    sat  = |full[FULL_W-1:PROD_WIDTH];
    p    = sat ? {PROD_WIDTH{1'b1}} : full[PROD_WIDTH-1:0];
  end

endmodule

// File: rtl/hps_product_engine.sv
// Harmonic-product-spectrum engine: per bin k, multiplies |X[floor(k/h)]| for
// h = 1..NUM_HARMONICS, streams the saturated products and tracks the peak bin.
module hps_product_engine
  import hps_pkg::*;
#(
  parameter int K_WIDTH       = 12,
  parameter int K_MIN         = 1,
  parameter int NUM_HARMONICS = 3,
  parameter int MAG_WIDTH     = 16,
  parameter int PROD_WIDTH    = 32,
  parameter int RAM_LATENCY   = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  clear,
  output logic [K_WIDTH-1:0]    ram_addr,
  output logic                  ram_en,
  input  logic [MAG_WIDTH-1:0]  ram_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [K_WIDTH-1:0]    out_k,
  output logic [PROD_WIDTH-1:0] out_prod,
  output logic                  out_sat,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic [K_WIDTH-1:0]    peak_k,
  output logic [PROD_WIDTH-1:0] peak_prod
);

  localparam logic [K_WIDTH-1:0] K_MAX   = {1'b0, {(K_WIDTH-1){1'b1}}};
  localparam logic [K_WIDTH-1:0] K_FIRST = K_WIDTH'(K_MIN);
  localparam int                 IDX_W   = clog2(NUM_HARMONICS + 1);
  localparam logic [IDX_W-1:0]   NUM_RD  = IDX_W'(NUM_HARMONICS);
  localparam logic [IDX_W-1:0]   LAST_RD = IDX_W'(NUM_HARMONICS - 1);
  localparam int                 R_W     = 4;

  hps_state_e            state, state_nx;
  logic [K_WIDTH-1:0]    k;
  logic [IDX_W-1:0]      rd_cnt;
  logic [K_WIDTH-1:0]    quo_vec [NUM_HARMONICS];
  logic [PROD_WIDTH-1:0] acc, mul_p;
  logic                  sat_flag, mul_sat;
  logic [RAM_LATENCY-1:0] vpipe;
  logic [IDX_W-1:0]      ipipe [RAM_LATENCY];
  logic                  launch, handshake, advance, cap_valid;
  logic [IDX_W-1:0]      cap_idx;

  // out_valid/out_ready: a transfer happens in any cycle where both are high.
  // While valid waits for ready, out_k/out_prod/out_sat hold and no reads issue;
  // valid only drops after a transfer, or on clear/reset.
  assign launch    = (state == ST_IDLE) && start && !clear;
  assign handshake = (state == ST_OUT) && out_ready && !clear;
  assign advance   = handshake && (k != K_MAX);
  assign ram_en    = (state == ST_READ) && (rd_cnt < NUM_RD);
  assign cap_valid = vpipe[RAM_LATENCY-1] && (state == ST_READ);
  assign cap_idx   = ipipe[RAM_LATENCY-1];

  assign out_valid = (state == ST_OUT);
  assign out_k     = k;
  assign out_prod  = acc;
  assign out_sat   = sat_flag;
  assign out_last  = out_valid && (k == K_MAX);
  assign busy      = (state == ST_READ) || (state == ST_OUT);
  assign done      = (state == ST_DONE);

  // floor(k/h) tracked incrementally: the remainder wraps at h and bumps the quotient.
  for (genvar g = 0; g < NUM_HARMONICS; g++) begin : g_harm
    localparam int               H_VAL  = g + 1;
    localparam logic [K_WIDTH-1:0] Q0   = K_WIDTH'(K_MIN / H_VAL);
    localparam logic [R_W-1:0]   R0     = R_W'(K_MIN % H_VAL);
    localparam logic [R_W-1:0]   H_LAST = R_W'(H_VAL - 1);
    logic [K_WIDTH-1:0] quo;
    logic [R_W-1:0]     rem;

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        quo <= '0;
        rem <= '0;
      end else if (launch) begin
        quo <= Q0;
        rem <= R0;
      end else if (advance) begin
        if (rem == H_LAST) begin
          rem <= '0;
          quo <= quo + 1'b1;
        end else begin
          rem <= rem + 1'b1;
        end
      end
    end

    assign quo_vec[g] = quo;
  end

  always_comb begin
    ram_addr = '0;
    for (int i = 0; i < NUM_HARMONICS; i++) begin
      if (ram_en && (rd_cnt == IDX_W'(i))) ram_addr = quo_vec[i];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (start) state_nx = ST_READ;
      ST_READ: if (cap_valid && (cap_idx == LAST_RD)) state_nx = ST_OUT;
      ST_OUT:  if (out_ready) state_nx = (k == K_MAX) ? ST_DONE : ST_READ;
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
    if (clear) state_nx = ST_IDLE;
  end

  // Tags each outstanding read with its harmonic index; clear drops anything in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vpipe <= '0;
      for (int i = 0; i < RAM_LATENCY; i++) ipipe[i] <= '0;
    end else begin
      vpipe[0] <= ram_en && !clear;
      ipipe[0] <= rd_cnt;
      for (int i = 1; i < RAM_LATENCY; i++) begin
        vpipe[i] <= vpipe[i-1] && !clear;
        ipipe[i] <= ipipe[i-1];
      end
    end
  end

  hps_sat_mul #(
    .PROD_WIDTH(PROD_WIDTH),
    .MAG_WIDTH (MAG_WIDTH)
  ) u_sat_mul (
    .a  (acc),
    .b  (ram_data),
    .p  (mul_p),
    .sat(mul_sat)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      k         <= '0;
      rd_cnt    <= '0;
      acc       <= '0;
      sat_flag  <= 1'b0;
      peak_prod <= '0;
      peak_k    <= K_FIRST;
    end else begin
      if (launch) begin
        k         <= K_FIRST;
        rd_cnt    <= '0;
        peak_prod <= '0;
        peak_k    <= K_FIRST;
      end else begin
        if (ram_en) rd_cnt <= rd_cnt + 1'b1;
        if (handshake) begin
          rd_cnt <= '0;
          // Strict compare keeps the lower bin on ties.
          if (acc > peak_prod) begin
            peak_prod <= acc;
            peak_k    <= k;
          end
        end
        if (advance) k <= k + 1'b1;
      end
      if (cap_valid) begin
        if (cap_idx == '0) begin
          acc      <= PROD_WIDTH'(ram_data);
          sat_flag <= 1'b0;
        end else begin
          acc      <= mul_p;
          sat_flag <= sat_flag | mul_sat;
        end
      end
    end
  end

endmodule
